// File: rtl/seg_pkg.sv
// Shared types and segment encoding for the seven-segment scanner.
package seg_pkg;

    typedef enum logic {BLANK, DRIVE} scan_state_t;

    localparam int NUM_DIGITS = 8;

    // {a,b,c,d,e,f,g}, active-high, indexed by hex nibble
    localparam logic [6:0] SEG_LUT [16] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
        7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
    };

    function automatic logic [6:0] seg_encode(input logic [3:0] nibble);
        return SEG_LUT[nibble];
    endfunction

endpackage

// File: rtl/seg_slot_timer.sv
// Slot tick counter and digit index for the scanner; flags slot/blank/frame boundaries.
module seg_slot_timer #(
    parameter int TICKS        = 100_000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    output logic [2:0] idx,
    output logic       slot_start,
    output logic       slot_last,
    output logic       blank,
    output logic       blank_last,
    output logic       frame_wrap
);
    localparam int TW = (TICKS > 1) ? $clog2(TICKS) : 1;

    logic [TW-1:0] tick_r;
    logic [2:0]    idx_r;

    assign idx        = idx_r;
    assign slot_start = (tick_r == TW'(0));
    assign slot_last  = (tick_r == TW'(TICKS - 1));
    assign blank      = (tick_r <  TW'(BLANK_CYCLES));
    assign blank_last = (tick_r == TW'(BLANK_CYCLES - 1));
    assign frame_wrap = slot_last && (idx_r == 3'd7);

    // Tick counter wraps each slot; digit index advances on the wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_r <= '0;
            idx_r  <= 3'd0;
        end else if (slot_last) begin
            tick_r <= '0;
            idx_r  <= (idx_r == 3'd7) ? 3'd0 : idx_r + 3'd1;
        end else begin
            tick_r <= tick_r + TW'(1);
        end
    end

endmodule

// File: rtl/seven_seg_scanner.sv
// Nexys A7 8-digit seven-segment scanner with double-buffered display data.
// Optional build macro: LEADING_ZERO_BLANK_EN (suppresses leading zero digits).
module seven_seg_scanner
    import seg_pkg::*;
#(
    parameter int CLK_HZ       = 100_000_000,
    parameter int DIGIT_HZ     = 1_000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] value,
    input  logic [7:0]  dp_in,
    input  logic [7:0]  digit_en,
    output logic [7:0]  an_n,
    output logic [6:0]  seg_n,
    output logic        dp_n,
    output logic        frame_start
);
    localparam int TICKS = CLK_HZ / DIGIT_HZ;

    logic [2:0]  idx_s;
    logic        slot_start_s, slot_last_s, blank_s, blank_last_s, frame_wrap_s;
    logic [31:0] pend_val_r, act_val_r;
    logic [7:0]  pend_dp_r, act_dp_r, pend_en_r, act_en_r;
    scan_state_t state_r, next_state_s;
    logic [NUM_DIGITS-1:0] supp_s;
    logic        show_s;
    logic [3:0]  nibble_s;
    logic [7:0]  an_d_s;
    logic [6:0]  seg_d_s;
    logic        dp_d_s, fs_d_s;

    seg_slot_timer #(.TICKS(TICKS), .BLANK_CYCLES(BLANK_CYCLES)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .idx        (idx_s),
        .slot_start (slot_start_s),
        .slot_last  (slot_last_s),
        .blank      (blank_s),
        .blank_last (blank_last_s),
        .frame_wrap (frame_wrap_s)
    );

    // Pending buffer: every load overwrites, so the last load in a frame wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_val_r <= 32'd0;
            pend_dp_r  <= 8'd0;
            pend_en_r  <= 8'd0;
        end else if (load) begin
            pend_val_r <= value;
            pend_dp_r  <= dp_in;
            pend_en_r  <= digit_en;
        end
    end

    // Active buffer swaps only at the frame boundary; a load on that cycle goes straight in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_val_r <= 32'd0;
            act_dp_r  <= 8'd0;
            act_en_r  <= 8'd0;
        end else if (frame_wrap_s) begin
            act_val_r <= load ? value    : pend_val_r;
            act_dp_r  <= load ? dp_in    : pend_dp_r;
            act_en_r  <= load ? digit_en : pend_en_r;
        end
    end

    // Slot FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= BLANK;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Slot FSM next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            BLANK: begin
                if (blank_last_s) next_state_s = DRIVE;
                else              next_state_s = BLANK;
            end
            DRIVE: begin
                if (slot_last_s) next_state_s = BLANK;
                else             next_state_s = DRIVE;
            end
            default: next_state_s = BLANK;
        endcase
    end

    // Digit i>0 is a leading zero when nibbles 7..i are all zero.
    always_comb begin
        supp_s = '0;
`ifdef LEADING_ZERO_BLANK_EN
        for (int i = 1; i < NUM_DIGITS; i++) begin
            supp_s[i] = ((act_val_r >> (4 * i)) == 32'd0);
        end
`endif
    end

    assign nibble_s = act_val_r[{idx_s, 2'b00} +: 4];
    assign show_s   = act_en_r[idx_s] & ~supp_s[idx_s];

    // Pin values for the current slot position; blanked state drives everything off.
    always_comb begin
        an_d_s  = 8'hFF;
        seg_d_s = 7'h7F;
        dp_d_s  = 1'b1;
        fs_d_s  = slot_start_s && (idx_s == 3'd0);
        case (state_r)
            BLANK: begin
                an_d_s  = 8'hFF;
                seg_d_s = 7'h7F;
                dp_d_s  = 1'b1;
            end
            DRIVE: begin
                if (!blank_s) begin
                    an_d_s  = ~({7'd0, show_s} << idx_s);
                    seg_d_s = ~seg_encode(nibble_s);
                    dp_d_s  = ~(act_dp_r[idx_s] & ~supp_s[idx_s]);
                end else begin
                    an_d_s  = 8'hFF;
                    seg_d_s = 7'h7F;
                    dp_d_s  = 1'b1;
                end
            end
            default: begin
                an_d_s  = 8'hFF;
                seg_d_s = 7'h7F;
                dp_d_s  = 1'b1;
            end
        endcase
    end

    // Registered pins, one cycle behind the scan state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an_n        <= 8'hFF;
            seg_n       <= 7'h7F;
            dp_n        <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            an_n        <= an_d_s;
            seg_n       <= seg_d_s;
            dp_n        <= dp_d_s;
            frame_start <= fs_d_s;
        end
    end

endmodule
